// File: rtl/hazard_sb_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_sb_unit_pkg
// Shared encodings for the scoreboard hazard/forwarding controller.
//   fwd_sel_e   : EX-stage operand source select (register file, MEM/WB, EX/MEM)
//   PC_SEL_*    : PC source encodings used by the fetch mux
// ---------------------------------------------------------------------------
package hazard_sb_unit_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,   // operand from register file
        FWD_WB   = 2'b01,   // operand from MEM/WB result
        FWD_MEM  = 2'b10    // operand from EX/MEM result
    } fwd_sel_e;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // sequential fetch
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;  // taken branch target
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;  // jump / jalr target
    localparam logic [1:0] PC_SEL_TRAP   = 2'b11;  // trap vector

endpackage : hazard_sb_unit_pkg

// File: rtl/hazard_fwd_mux.sv
// ---------------------------------------------------------------------------
// hazard_fwd_mux
// Forwarding compare for one EX operand. The youngest producer (EX/MEM)
// wins over MEM/WB; x0 is never forwarded.
// Ports:
//   ex_rs_addr              : EX operand source register
//   mem_rd_addr/mem_reg_write : producer in EX/MEM
//   wb_rd_addr/wb_reg_write   : producer in MEM/WB
//   fwd_sel                 : selected operand source
// ---------------------------------------------------------------------------
module hazard_fwd_mux
    import hazard_sb_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs_addr,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_write,
    output fwd_sel_e          fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == ex_rs_addr);
    assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == ex_rs_addr);

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        fwd_sel = FWD_NONE;
        if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule : hazard_fwd_mux

// File: rtl/hazard_sb_unit.sv
// ---------------------------------------------------------------------------
// hazard_sb_unit
// Scoreboard-based hazard and forwarding controller for the 5-stage core.
// Each architectural register carries a countdown of cycles until its
// pending result can be consumed from ID; loads, ALU and multi-cycle ops
// all use the same mechanism.
// Ports:
//   clk_i, rst_n_i            : clock (rising edge), async active-low reset
//   id_*                      : instruction currently in ID
//   mc_busy_i                 : multi-cycle unit occupied
//   ex_rs1/2_addr_i           : EX operand sources (forwarding)
//   mem_*/wb_*                : producers in EX/MEM and MEM/WB
//   redirect_i, redirect_pc_sel_i : taken branch/jump resolved in MEM
//   pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o : pipeline control
//   forward_a/b_select_o      : EX operand source selects
//   pc_sel_final_o            : PC source for the fetch mux
//   sb_busy_o                 : per-register pending-result flags
//   stall_cnt_o, flush_cnt_o  : saturating performance counters
// ---------------------------------------------------------------------------
module hazard_sb_unit
    import hazard_sb_unit_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 7,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                id_valid_i,
    input  logic [REG_AW-1:0]   id_rs1_addr_i,
    input  logic [REG_AW-1:0]   id_rs2_addr_i,
    input  logic                id_rs1_used_i,
    input  logic                id_rs2_used_i,
    input  logic [REG_AW-1:0]   id_rd_addr_i,
    input  logic                id_reg_write_i,
    input  logic [LAT_W-1:0]    id_lat_i,
    input  logic                id_is_mc_i,
    input  logic                mc_busy_i,
    input  logic [REG_AW-1:0]   ex_rs1_addr_i,
    input  logic [REG_AW-1:0]   ex_rs2_addr_i,
    input  logic [REG_AW-1:0]   mem_rd_addr_i,
    input  logic                mem_reg_write_i,
    input  logic [REG_AW-1:0]   wb_rd_addr_i,
    input  logic                wb_reg_write_i,
    input  logic                redirect_i,
    input  logic [1:0]          redirect_pc_sel_i,
    output logic                pc_stall_o,
    output logic                if_id_stall_o,
    output logic                if_id_flush_o,
    output logic                id_ex_flush_o,
    output logic [1:0]          forward_a_select_o,
    output logic [1:0]          forward_b_select_o,
    output logic [1:0]          pc_sel_final_o,
    output logic [NUM_REGS-1:0] sb_busy_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o
);

    // Compared one bit wider so the clamp stays meaningful when MAX_LAT
    // already fills the latency field.
    localparam logic [LAT_W:0] MAX_LAT_EXT = (LAT_W + 1)'(MAX_LAT);

    logic [LAT_W-1:0]  busy_cnt [NUM_REGS];
    logic [REG_AW-1:0] last_rd;
    logic              last_wr;

    logic [LAT_W-1:0]  lat_eff;
    logic              rd_valid;
    logic              raw_rs1;
    logic              raw_rs2;
    logic              waw;
    logic              structural;
    logic              stall;
    logic              issue;
    fwd_sel_e          fwd_a;
    fwd_sel_e          fwd_b;

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    assign lat_eff    = ({1'b0, id_lat_i} > MAX_LAT_EXT) ? MAX_LAT_EXT[LAT_W-1:0] : id_lat_i;
    assign rd_valid   = id_reg_write_i && (id_rd_addr_i != '0);

    assign raw_rs1    = id_rs1_used_i && (id_rs1_addr_i != '0) && (busy_cnt[id_rs1_addr_i] != '0);
    assign raw_rs2    = id_rs2_used_i && (id_rs2_addr_i != '0) && (busy_cnt[id_rs2_addr_i] != '0);
    // A younger writer must not finish before an older one still in flight.
    assign waw        = rd_valid && (busy_cnt[id_rd_addr_i] > lat_eff);
    assign structural = id_is_mc_i && mc_busy_i;

    assign stall = id_valid_i && (raw_rs1 || raw_rs2 || waw || structural);
    assign issue = id_valid_i && !stall && !redirect_i;

    // ---------------------------------------------------------------------
    // Scoreboard: load on issue > squash on redirect > decrement
    // ---------------------------------------------------------------------
    // NOTE: the count array is reset explicitly because its contents drive
    // stalls combinationally; stale counts after reset would freeze the pipe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_cnt[r] <= '0;
            end
        end else begin
            // Entry 0 is skipped so x0 never reports a pending result.
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && rd_valid && (id_rd_addr_i == REG_AW'(r))) begin
                    busy_cnt[r] <= lat_eff;
                end else if (redirect_i && last_wr && (last_rd == REG_AW'(r))) begin
                    busy_cnt[r] <= '0;
                end else if (busy_cnt[r] != '0) begin
                    busy_cnt[r] <= busy_cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // Remembers the instruction that just entered EX so a redirect in the
    // following cycle can cancel its scoreboard entry.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_rd <= '0;
            last_wr <= 1'b0;
        end else if (issue) begin
            last_rd <= id_rd_addr_i;
            last_wr <= rd_valid;
        end else begin
            last_rd <= '0;
            last_wr <= 1'b0;
        end
    end

    always_comb begin
        sb_busy_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_busy_o[r] = (busy_cnt[r] != '0);
        end
    end

    // ---------------------------------------------------------------------
    // Saturating performance counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && !redirect_i && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (redirect_i && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pipeline control: a redirect flushes the stalled instruction anyway,
    // so it overrides the stall on PC and IF/ID.
    // ---------------------------------------------------------------------
    assign pc_stall_o     = stall && !redirect_i;
    assign if_id_stall_o  = stall && !redirect_i;
    assign if_id_flush_o  = redirect_i;
    assign id_ex_flush_o  = stall || redirect_i;
    assign pc_sel_final_o = redirect_i ? redirect_pc_sel_i : PC_SEL_SEQ;

    // ---------------------------------------------------------------------
    // EX forwarding
    // ---------------------------------------------------------------------
    hazard_fwd_mux #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_rs_addr    (ex_rs1_addr_i),
        .mem_rd_addr   (mem_rd_addr_i),
        .mem_reg_write (mem_reg_write_i),
        .wb_rd_addr    (wb_rd_addr_i),
        .wb_reg_write  (wb_reg_write_i),
        .fwd_sel       (fwd_a)
    );

    hazard_fwd_mux #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_rs_addr    (ex_rs2_addr_i),
        .mem_rd_addr   (mem_rd_addr_i),
        .mem_reg_write (mem_reg_write_i),
        .wb_rd_addr    (wb_rd_addr_i),
        .wb_reg_write  (wb_reg_write_i),
        .fwd_sel       (fwd_b)
    );

    assign forward_a_select_o = fwd_a;
    assign forward_b_select_o = fwd_b;

endmodule : hazard_sb_unit

// File: tb/tb_hazard_sb_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_sb_unit
// Directed bench for hazard_sb_unit. Expectations are queued while each
// cycle's stimulus is driven and drained against the DUT at the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_sb_unit;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int MAX_LAT  = 7;
    localparam int LAT_W    = 3;
    localparam int CNT_W    = 32;

    typedef enum {
        S_PC_STALL, S_IFID_STALL, S_IFID_FLUSH, S_IDEX_FLUSH,
        S_FWD_A, S_FWD_B, S_PC_SEL, S_SB_BIT, S_SB_BUSY,
        S_STALL_CNT, S_FLUSH_CNT
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid;
    logic [REG_AW-1:0]   id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic                id_rs1_used, id_rs2_used, id_reg_write;
    logic [LAT_W-1:0]    id_lat;
    logic                id_is_mc, mc_busy;
    logic [REG_AW-1:0]   ex_rs1_addr, ex_rs2_addr, mem_rd_addr, wb_rd_addr;
    logic                mem_reg_write, wb_reg_write;
    logic                redirect;
    logic [1:0]          redirect_pc_sel;
    logic                pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic [1:0]          forward_a_select, forward_b_select, pc_sel_final;
    logic [NUM_REGS-1:0] sb_busy;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_sb_unit #(
        .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MAX_LAT(MAX_LAT),
        .LAT_W(LAT_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .id_valid_i         (id_valid),
        .id_rs1_addr_i      (id_rs1_addr),
        .id_rs2_addr_i      (id_rs2_addr),
        .id_rs1_used_i      (id_rs1_used),
        .id_rs2_used_i      (id_rs2_used),
        .id_rd_addr_i       (id_rd_addr),
        .id_reg_write_i     (id_reg_write),
        .id_lat_i           (id_lat),
        .id_is_mc_i         (id_is_mc),
        .mc_busy_i          (mc_busy),
        .ex_rs1_addr_i      (ex_rs1_addr),
        .ex_rs2_addr_i      (ex_rs2_addr),
        .mem_rd_addr_i      (mem_rd_addr),
        .mem_reg_write_i    (mem_reg_write),
        .wb_rd_addr_i       (wb_rd_addr),
        .wb_reg_write_i     (wb_reg_write),
        .redirect_i         (redirect),
        .redirect_pc_sel_i  (redirect_pc_sel),
        .pc_stall_o         (pc_stall),
        .if_id_stall_o      (if_id_stall),
        .if_id_flush_o      (if_id_flush),
        .id_ex_flush_o      (id_ex_flush),
        .forward_a_select_o (forward_a_select),
        .forward_b_select_o (forward_b_select),
        .pc_sel_final_o     (pc_sel_final),
        .sb_busy_o          (sb_busy),
        .stall_cnt_o        (stall_cnt),
        .flush_cnt_o        (flush_cnt)
    );

    function automatic logic [31:0] observe(input sig_e s, input int idx);
        logic [4:0] bit_idx;
        bit_idx = idx[4:0];
        case (s)
            S_PC_STALL:   return {31'b0, pc_stall};
            S_IFID_STALL: return {31'b0, if_id_stall};
            S_IFID_FLUSH: return {31'b0, if_id_flush};
            S_IDEX_FLUSH: return {31'b0, id_ex_flush};
            S_FWD_A:      return {30'b0, forward_a_select};
            S_FWD_B:      return {30'b0, forward_b_select};
            S_PC_SEL:     return {30'b0, pc_sel_final};
            S_SB_BIT:     return {31'b0, sb_busy[bit_idx]};
            S_SB_BUSY:    return sb_busy;
            S_STALL_CNT:  return stall_cnt;
            S_FLUSH_CNT:  return flush_cnt;
            default:      return 'x;
        endcase
    endfunction

    task automatic want(input string tag, input sig_e s, input logic [31:0] v, input int idx = 0);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.idx = idx;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    // Compare every queued expectation against the DUT as it is right now.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sig, e.idx);
            tests++;
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        drain();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we,
                          input logic [2:0] lat, input logic mc);
        id_valid     = v;
        id_rs1_addr  = rs1;
        id_rs1_used  = u1;
        id_rs2_addr  = rs2;
        id_rs2_used  = u2;
        id_rd_addr   = rd;
        id_reg_write = we;
        id_lat       = lat;
        id_is_mc     = mc;
    endtask

    task automatic set_ex(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] mrd, input logic mwe,
                          input logic [4:0] wrd, input logic wwe);
        ex_rs1_addr   = rs1;
        ex_rs2_addr   = rs2;
        mem_rd_addr   = mrd;
        mem_reg_write = mwe;
        wb_rd_addr    = wrd;
        wb_reg_write  = wwe;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ex(0, 0, 0, 0, 0, 0);
        mc_busy = 1'b0;
        redirect = 1'b0;
        redirect_pc_sel = 2'b00;
        want("rst_sb_busy", S_SB_BUSY, 32'h0);
        want("rst_pc_stall", S_PC_STALL, 0);
        want("rst_idex_flush", S_IDEX_FLUSH, 0);
        want("rst_ifid_flush", S_IFID_FLUSH, 0);
        want("rst_fwd_a", S_FWD_A, 0);
        want("rst_pc_sel", S_PC_SEL, 0);
        want("rst_stall_cnt", S_STALL_CNT, 0);
        want("rst_flush_cnt", S_FLUSH_CNT, 0);
        sample();
        #2 rst_n = 1'b1;
        next_cycle();

        // ---------------- load-use: lw x5 (lat 1); add x6,x5,x1 ----------------
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);
        want("lw_issue_no_stall", S_PC_STALL, 0);
        sample();
        next_cycle();
        set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
        want("lu_pc_stall", S_PC_STALL, 1);
        want("lu_ifid_stall", S_IFID_STALL, 1);
        want("lu_idex_flush", S_IDEX_FLUSH, 1);
        want("lu_sb_busy5", S_SB_BIT, 1, 5);
        sample();
        next_cycle();
        set_ex(5, 1, 5, 1, 0, 0);
        want("lu_release", S_PC_STALL, 0);
        want("lu_release_flush", S_IDEX_FLUSH, 0);
        want("lu_fwd_a_mem", S_FWD_A, 2'b10);
        want("lu_fwd_b_none", S_FWD_B, 2'b00);
        want("lu_stall_cnt", S_STALL_CNT, 1);
        sample();
        next_cycle();

        // ---------------- RAW on div x7 (lat 4) ----------------
        set_ex(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 0, 0, 0, 7, 1, 4, 1);
        want("div_issue", S_PC_STALL, 0);
        sample();
        next_cycle();
        set_id(1, 7, 1, 0, 0, 8, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            want($sformatf("raw_div_stall_%0d", i), S_PC_STALL, 1);
            want($sformatf("raw_div_busy7_%0d", i), S_SB_BIT, 1, 7);
            sample();
            next_cycle();
        end
        want("raw_div_release", S_PC_STALL, 0);
        want("raw_div_busy7_clear", S_SB_BIT, 0, 7);
        want("raw_div_stall_cnt", S_STALL_CNT, 1 + 4);
        sample();
        next_cycle();

        // ---------------- WAW: div x7 (lat 4), add x7 (lat 0) ----------------
        set_id(1, 0, 0, 0, 0, 7, 1, 4, 1);
        sample();
        next_cycle();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            want($sformatf("waw_stall_%0d", i), S_PC_STALL, 1);
            sample();
            next_cycle();
        end
        want("waw_release", S_PC_STALL, 0);
        want("waw_stall_cnt", S_STALL_CNT, 5 + 4);
        sample();
        next_cycle();

        // ---------------- structural: mc op while unit busy ----------------
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
        mc_busy = 1'b1;
        want("struct_stall", S_PC_STALL, 1);
        want("struct_idex_flush", S_IDEX_FLUSH, 1);
        sample();
        next_cycle();

        // ---------------- redirect squashes lw x9 ----------------
        mc_busy = 1'b0;
        set_id(1, 0, 0, 0, 0, 9, 1, 1, 0);
        want("lw9_issue", S_PC_STALL, 0);
        want("struct_stall_cnt", S_STALL_CNT, 10);
        sample();
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        redirect = 1'b1;
        redirect_pc_sel = 2'b01;
        want("redir_ifid_flush", S_IFID_FLUSH, 1);
        want("redir_idex_flush", S_IDEX_FLUSH, 1);
        want("redir_pc_sel", S_PC_SEL, 2'b01);
        want("redir_busy9_before", S_SB_BIT, 1, 9);
        sample();
        next_cycle();
        redirect = 1'b0;
        want("redir_busy9_after", S_SB_BIT, 0, 9);
        want("redir_flush_cnt", S_FLUSH_CNT, 1);
        want("redir_pc_sel_off", S_PC_SEL, 2'b00);
        sample();
        next_cycle();

        // ---------------- redirect vs stall, longer latency squashed ----------------
        set_id(1, 0, 0, 0, 0, 9, 1, 3, 1);
        sample();
        next_cycle();
        set_id(1, 9, 1, 0, 0, 11, 1, 0, 0);
        redirect = 1'b1;
        redirect_pc_sel = 2'b10;
        want("rs_pc_stall", S_PC_STALL, 0);
        want("rs_ifid_stall", S_IFID_STALL, 0);
        want("rs_idex_flush", S_IDEX_FLUSH, 1);
        want("rs_ifid_flush", S_IFID_FLUSH, 1);
        want("rs_pc_sel", S_PC_SEL, 2'b10);
        sample();
        next_cycle();
        redirect = 1'b0;
        want("rs_busy9_squashed", S_SB_BIT, 0, 9);
        want("rs_no_stall", S_PC_STALL, 0);
        want("rs_stall_cnt", S_STALL_CNT, 10);
        want("rs_flush_cnt", S_FLUSH_CNT, 2);
        sample();
        next_cycle();

        // ---------------- forwarding priority ----------------
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ex(3, 0, 3, 1, 3, 1);
        want("fwd_a_mem_over_wb", S_FWD_A, 2'b10);
        want("fwd_b_x0", S_FWD_B, 2'b00);
        sample();
        next_cycle();
        set_ex(3, 4, 4, 0, 3, 1);
        want("fwd_a_wb", S_FWD_A, 2'b01);
        want("fwd_b_mem_no_we", S_FWD_B, 2'b00);
        sample();
        next_cycle();
        set_ex(0, 4, 0, 1, 4, 1);
        want("fwd_a_x0_producer", S_FWD_A, 2'b00);
        want("fwd_b_wb", S_FWD_B, 2'b01);
        sample();
        next_cycle();

        // ---------------- issue onto expiring count ----------------
        set_ex(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 0, 0, 0, 10, 1, 1, 0);
        sample();
        next_cycle();
        set_id(1, 0, 0, 0, 0, 10, 1, 3, 0);
        want("expire_no_waw", S_PC_STALL, 0);
        want("expire_busy10", S_SB_BIT, 1, 10);
        sample();
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        want("expire_new_wins", S_SB_BIT, 1, 10);
        sample();
        next_cycle();

        // ---------------- async reset during div stall ----------------
        set_id(1, 0, 0, 0, 0, 12, 1, 4, 1);
        sample();
        next_cycle();
        set_id(1, 12, 1, 0, 0, 13, 1, 0, 0);
        want("pre_rst_stall", S_PC_STALL, 1);
        want("pre_rst_busy_vec", S_SB_BUSY, 32'h0000_1400);
        sample();
        #2 rst_n = 1'b0;
        #1;
        want("async_rst_pc_stall", S_PC_STALL, 0);
        want("async_rst_ifid_stall", S_IFID_STALL, 0);
        want("async_rst_idex_flush", S_IDEX_FLUSH, 0);
        want("async_rst_sb_busy", S_SB_BUSY, 32'h0);
        want("async_rst_stall_cnt", S_STALL_CNT, 0);
        want("async_rst_flush_cnt", S_FLUSH_CNT, 0);
        want("async_rst_fwd_a", S_FWD_A, 0);
        want("async_rst_pc_sel", S_PC_SEL, 0);
        drain();
        #1 rst_n = 1'b1;
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        want("post_rst_idle", S_PC_STALL, 0);
        sample();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_hazard_sb_unit

// File: doc/hazard_sb_unit.md
# hazard_sb_unit

Scoreboard-based hazard and forwarding controller for the 5-stage core, successor to the load-use-only hazard logic. It tracks per-register result latency, so loads, single-cycle ALU ops and multi-cycle ops (MUL/DIV) share one mechanism. It drives pipeline stall/flush, EX-stage forwarding selects and final PC select, and exposes saturating stall/flush performance counters. It sits beside the pipeline registers and is the only source of their stall/flush controls.

## Interface
- NUM_REGS, 32: architectural registers; x0 is hard-zero.
- REG_AW, 5: register address width; must equal $clog2(NUM_REGS).
- MAX_LAT, 7: largest result latency accepted on id_lat_i.
- LAT_W, $clog2(MAX_LAT+1): latency/counter width.
- CNT_W, 32: performance counter width.

Ports:
- clk_i in 1: clock, rising edge.
- rst_n_i in 1: asynchronous, active-low reset.
- id_valid_i in 1: ID holds a real instruction.
- id_rs1_addr_i, id_rs2_addr_i in REG_AW: ID source registers.
- id_rs1_used_i, id_rs2_used_i in 1: source actually read.
- id_rd_addr_i in REG_AW; id_reg_write_i in 1: ID destination.
- id_lat_i in LAT_W: cycles after issue before a consumer may leave ID (0 ALU, 1 load, >1 multi-cycle).
- id_is_mc_i in 1: ID instruction needs the multi-cycle unit; mc_busy_i in 1: that unit is occupied.
- ex_rs1_addr_i, ex_rs2_addr_i in REG_AW: EX sources.
- mem_rd_addr_i in REG_AW; mem_reg_write_i in 1. wb_rd_addr_i in REG_AW; wb_reg_write_i in 1.
- redirect_i in 1: taken branch/jump resolved in MEM; redirect_pc_sel_i in 2: PC source for it.
- pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o out 1.
- forward_a_select_o, forward_b_select_o out 2: 10 EX/MEM, 01 MEM/WB, 00 register file.
- pc_sel_final_o out 2.
- sb_busy_o out NUM_REGS: bit r set when busy_cnt[r] != 0.
- stall_cnt_o, flush_cnt_o out CNT_W.

## Operation
- Scoreboard: busy_cnt[r] (LAT_W) per register; entry 0 is never written.
- issue = id_valid_i & !stall & !redirect_i (instruction enters ID/EX this edge).
- Every cycle each nonzero busy_cnt decrements by 1. On issue with id_reg_write_i and rd != 0, busy_cnt[rd] loads id_lat_i; the load overrides the decrement.
- RAW stall: a used source != 0 whose busy_cnt != 0.
- WAW stall: id_reg_write_i, rd != 0, busy_cnt[rd] > id_lat_i.
- Structural stall: id_is_mc_i & mc_busy_i.
- stall = id_valid_i & (RAW | WAW | structural).
- Issue tracker: last_rd/last_wr register the rd and write flag of each issue, and are cleared otherwise. On redirect_i with last_wr set, busy_cnt[last_rd] clears to 0 (squashed EX instruction), overriding the decrement.
- Outputs: pc_stall_o = if_id_stall_o = stall & !redirect_i. if_id_flush_o = redirect_i. id_ex_flush_o = stall | redirect_i. pc_sel_final_o = redirect_i ? redirect_pc_sel_i : 00.
- Forwarding (combinational): MEM match (reg_write, rd != 0, rd == ex_rs) selects 10; otherwise a WB match selects 01; otherwise 00.
- stall_cnt_o increments on cycles with stall & !redirect_i; flush_cnt_o increments on redirect_i. Both saturate at all-ones.
- id_lat_i > MAX_LAT is illegal; the block clamps it to MAX_LAT.

## Timing
- Reset: all busy_cnt 0, last_wr 0, both counters 0. Outputs then: sb_busy_o 0, every stall/flush 0, forward selects 00, pc_sel_final_o 00.
- Stall/flush/forward/pc_sel outputs are combinational from inputs and current state; scoreboard updates on the next edge.
- A load (lat 1) followed by a dependent op gives exactly 1 stall cycle. lat N gives N stall cycles. ALU (lat 0) gives none.
- Redirect and stall in the same cycle: the flush wins, and neither PC nor IF/ID stalls.
- Issue to a register whose count is expiring this cycle: the new value wins.
- Reset asserted mid-stall clears state immediately (asynchronously); stalls release without waiting for a clock edge.

## Structure
- The shared package holds the forward select encodings FWD_NONE/FWD_WB/FWD_MEM and the PC select constants, already in defines.v.
- Sub-module hazard_fwd_mux: the pure combinational forwarding compare, instantiated once per EX operand.
- The scoreboard array, issue tracker and counters live in the top module.

## Test plan
- Load x5 (lat 1), then add x6,x5,x1 → one cycle with pc_stall_o=1 and id_ex_flush_o=1; the next cycle forward_a_select_o=10.
- div x7 (lat 4), then use x7 → stall for 4 cycles; stall_cnt_o=4 and sb_busy_o[7] falls after the fourth cycle.
- div x7 lat 4, then add x7 lat 0 → WAW stall until busy_cnt[7]=0, then the add issues with no stall.
- Issue lw x9, then redirect_i=1 with sel 01 the next cycle → busy_cnt[9] cleared, if_id_flush_o=1, pc_sel_final_o=01, flush_cnt_o=1.
- MEM rd=x3 and WB rd=x3 both writing, ex_rs1=x3 → forward_a_select_o=10. With ex_rs2=x0 → forward_b_select_o=00.
- Assert rst_n_i during a 4-cycle div stall → all outputs 0 asynchronously, counters 0.
